// File: rtl/nes_pkg.sv
// Shared NES system definitions: bus widths, fixed register addresses and the
// sprite DMA state encoding.
package nes_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // CPU-visible register that starts a sprite DMA, and the PPU OAM data port.
  localparam logic [ADDR_W-1:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine. A CPU write of page N to the DMA register stalls the CPU
// and copies $NN00-$NNFF to the OAM data port, one read/write pair per byte.
// While idle the CPU bus passes straight through to the system bus.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = OAM_DMA_ADDR,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAMDATA_ADDR,
  parameter int                XFER_LEN      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_d_out,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_d_in,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_d_out,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_d_in,
  output logic              dma_active
);

  localparam int IDX_W = $clog2(XFER_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  dma_state_t              state;
  logic                    cyc_odd;
  logic [IDX_W-1:0]        index;
  logic [DATA_W-1:0]       page;
  logic [DATA_W-1:0]       data_buf;
  logic [ADDR_W-1:0]       src_addr;

  // Source address: the page forms the high byte, the index the low byte, so
  // page $FF ends at $FFFF with no carry anywhere.
  assign src_addr = {page, index};

  // State register, bus-parity flop, byte index and the read-to-write buffer.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cyc_odd  <= 1'b0;
      index    <= '0;
      page     <= '0;
      data_buf <= '0;
    end else begin
      cyc_odd <= ~cyc_odd;
      unique case (state)
        IDLE: begin
          if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
            page  <= cpu_d_out;
            index <= '0;
            state <= HALT;
          end
        end
        // A read may only land on an even bus cycle; if the next cycle would be
        // odd, burn one extra ALIGN cycle first.
        HALT:  state <= cyc_odd ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          data_buf <= bus_d_in;
          state    <= WRITE;
        end
        // Termination is by compare against the last index, never by overflow.
        WRITE: begin
          if (index == LAST_IDX) begin
            index <= '0;
            state <= IDLE;
          end else begin
            index <= index + 1'b1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // System bus drive: CPU pass-through when idle, DMA addressing otherwise.
  // NOTE: every output gets a default before the case so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_we    = 1'b0;
    unique case (state)
      IDLE:  bus_we = cpu_we;
      READ:  bus_addr = src_addr;
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = data_buf;
        bus_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // CPU-side status is decoded from the registered state only.
  assign cpu_rdy    = (state == IDLE);
  assign dma_active = (state != IDLE);
  assign cpu_d_in   = bus_d_in;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: pass-through, even/odd triggers, page $FF,
// reset mid-transfer and back-to-back transfers against a byte memory model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  int          errors = 0;
  int          checks = 0;

  // Bench view of the bus parity: 0 out of reset, toggling every clock.
  logic        par;

  // Captured OAM writes and the address read in the cycle before each one.
  logic [7:0]  wq [$];
  logic [15:0] rq [$];
  logic [15:0] prev_addr = 16'h0000;
  int          bad_we = 0;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_d_out (cpu_d_out),
    .cpu_we    (cpu_we),
    .cpu_d_in  (cpu_d_in),
    .cpu_rdy   (cpu_rdy),
    .bus_addr  (bus_addr),
    .bus_d_out (bus_d_out),
    .bus_we    (bus_we),
    .bus_d_in  (bus_d_in),
    .dma_active(dma_active)
  );

  assign bus_d_in = mem[bus_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else      par <= ~par;
  end

  always @(negedge clk) begin
    if (bus_we === 1'b1 && bus_addr === 16'h2004) begin
      wq.push_back(bus_d_out);
      rq.push_back(prev_addr);
    end
    if (cpu_rdy === 1'b0 && bus_we === 1'b1 && bus_addr !== 16'h2004) bad_we++;
    prev_addr = bus_addr;
  end

  task automatic clear_capture();
    wq.delete();
    rq.delete();
  endtask

  // Start a transfer on a cycle of the requested parity and check the trigger
  // write itself still reaches the bus.
  task automatic trigger(input logic [7:0] pg, input logic want_odd);
    do begin
      @(posedge clk);
      #1;
    end while (par !== want_odd);
    cpu_addr  = 16'h4014;
    cpu_d_out = pg;
    cpu_we    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 16'h4014 || bus_d_out !== pg || cpu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL trigger_pass: we=%b addr=%h d=%h rdy=%b, expected 1 4014 %h 1",
               bus_we, bus_addr, bus_d_out, cpu_rdy, pg);
    end
  endtask

  // Count stalled cycles after the trigger cycle; also grab the second stall cycle.
  task automatic wait_rdy(input bit hold, output int n, output logic we1, output logic [15:0] a1);
    n   = 0;
    we1 = 1'bx;
    a1  = 16'hxxxx;
    @(posedge clk);
    #1;
    if (!hold) begin
      cpu_we   = 1'b0;
      cpu_addr = 16'hC000;
    end
    while (1) begin
      @(negedge clk);
      if (cpu_rdy === 1'b1) break;
      if (n == 1) begin
        we1 = bus_we;
        a1  = bus_addr;
      end
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: still stalled after %0d cycles, expected release", n);
        break;
      end
    end
  endtask

  task automatic check_xfer(input string name, input logic [7:0] pg, input int exp_n, input int n);
    int dbad, abad, first;
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s_stall: got %0d cycles, expected %0d", name, n, exp_n);
    end
    checks++;
    if (wq.size() !== 256) begin
      errors++;
      $display("FAIL %s_count: got %0d OAM writes, expected 256", name, wq.size());
    end
    dbad = 0; abad = 0; first = -1;
    for (int i = 0; i < 256 && i < wq.size(); i++) begin
      if (wq[i] !== mem[{pg, 8'(i)}]) begin
        dbad++;
        if (first < 0) first = i;
      end
      if (rq[i] !== {pg, 8'(i)}) abad++;
    end
    checks++;
    if (dbad != 0) begin
      errors++;
      $display("FAIL %s_data: %0d bad bytes, first at %0d got %h expected %h",
               name, dbad, first, wq[first], mem[{pg, 8'(first)}]);
    end
    checks++;
    if (abad != 0) begin
      errors++;
      $display("FAIL %s_raddr: %0d bad read addresses, expected %h00..%hFF", name, abad, pg, pg);
    end
  endtask

  task automatic test_reset();
    cpu_addr  = 16'h1234;
    cpu_d_out = 8'h5A;
    cpu_we    = 1'b1;
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: rdy=%b active=%b, expected 1 0", cpu_rdy, dma_active);
    end
    checks++;
    if (bus_addr !== 16'h1234 || bus_we !== 1'b1 || bus_d_out !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pass: addr=%h we=%b d=%h, expected 1234 1 5a", bus_addr, bus_we, bus_d_out);
    end
    cpu_we = 1'b0;
    #23;
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    @(posedge clk);
    #1;
    cpu_addr = 16'h8000;
    cpu_we   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_addr !== 16'h8000 || cpu_d_in !== 8'hA9) begin
      errors++;
      $display("FAIL pass_read: addr=%h d_in=%h, expected 8000 a9", bus_addr, cpu_d_in);
    end
    checks++;
    if (cpu_rdy !== 1'b1 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL pass_read_ctl: rdy=%b we=%b, expected 1 0", cpu_rdy, bus_we);
    end
    @(posedge clk);
    #1;
    cpu_addr  = 16'h0200;
    cpu_d_out = 8'h55;
    cpu_we    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_we !== 1'b1 || bus_d_out !== 8'h55 || bus_addr !== 16'h0200) begin
      errors++;
      $display("FAIL pass_write: we=%b d=%h addr=%h, expected 1 55 0200", bus_we, bus_d_out, bus_addr);
    end
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic test_even();
    int n; logic we1; logic [15:0] a1;
    clear_capture();
    trigger(8'h02, 1'b0);
    wait_rdy(1'b0, n, we1, a1);
    check_xfer("even", 8'h02, 513, n);
    checks++;
    if (we1 !== 1'b0 || a1 !== 16'h0200) begin
      errors++;
      $display("FAIL even_first_read: we=%b addr=%h, expected 0 0200", we1, a1);
    end
  endtask

  task automatic test_odd();
    int n; logic we1; logic [15:0] a1;
    clear_capture();
    trigger(8'h02, 1'b1);
    wait_rdy(1'b0, n, we1, a1);
    check_xfer("odd", 8'h02, 514, n);
    checks++;
    if (we1 !== 1'b0 || a1 !== 16'hC000) begin
      errors++;
      $display("FAIL odd_align: we=%b addr=%h, expected 0 c000", we1, a1);
    end
  endtask

  task automatic test_page_ff();
    int n; logic we1; logic [15:0] a1;
    clear_capture();
    trigger(8'hFF, 1'b0);
    wait_rdy(1'b0, n, we1, a1);
    check_xfer("pageff", 8'hFF, 513, n);
    repeat (4) @(negedge clk);
    checks++;
    if (wq.size() !== 256 || rq.size() == 0 || rq[rq.size()-1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL pageff_end: writes=%0d last_read=%h, expected 256 ffff",
               wq.size(), (rq.size() == 0) ? 16'h0000 : rq[rq.size()-1]);
    end
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL pageff_idle: rdy=%b active=%b, expected 1 0", cpu_rdy, dma_active);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_capture();
    trigger(8'h02, 1'b0);
    @(posedge clk);
    #1;
    cpu_we   = 1'b0;
    cpu_addr = 16'hC000;
    guard = 0;
    while (wq.size() < 40 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (wq.size() < 40) begin
      errors++;
      $display("FAIL rstmid_reach: got %0d writes, expected 40", wq.size());
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || bus_we !== 1'b0 || dma_active !== 1'b0 || bus_addr !== 16'hC000) begin
      errors++;
      $display("FAIL rstmid_abort: rdy=%b we=%b active=%b addr=%h, expected 1 0 0 c000",
               cpu_rdy, bus_we, dma_active, bus_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    clear_capture();
    repeat (600) @(negedge clk);
    checks++;
    if (wq.size() !== 0 || cpu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_quiet: writes=%0d rdy=%b, expected 0 1", wq.size(), cpu_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int n; int exp_n; logic we1; logic [15:0] a1;
    clear_capture();
    trigger(8'h02, 1'b0);
    // CPU holds its $4014 write throughout the stall.
    wait_rdy(1'b1, n, we1, a1);
    check_xfer("hold", 8'h02, 513, n);
    // First cycle with cpu_rdy=1: issue the second trigger.
    cpu_d_out = 8'h03;
    exp_n = (par === 1'b1) ? 514 : 513;
    #1;
    clear_capture();
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 16'h4014 || bus_d_out !== 8'h03) begin
      errors++;
      $display("FAIL b2b_trigger: we=%b addr=%h d=%h, expected 1 4014 03", bus_we, bus_addr, bus_d_out);
    end
    wait_rdy(1'b0, n, we1, a1);
    check_xfer("b2b", 8'h03, exp_n, n);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h8000] = 8'hA9;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hFF;
      mem[16'h0300 + i] = {4'(i), 4'(i >> 4)};
      mem[16'hFF00 + i] = 8'(i + 8'h31);
    end
    test_reset();
    test_passthrough();
    test_even();
    test_odd();
    test_page_ff();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (bad_we !== 0) begin
      errors++;
      $display("FAIL stall_we: %0d non-OAM bus writes while stalled, expected 0", bad_we);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine between the 6502 `cpu` core and the system bus.
- A CPU write to the DMA register ($4014) with page value N halts the CPU via `cpu_rdy`. The engine then copies 256 bytes from $NN00–$NNFF to the PPU OAM data port ($2004), one read/write pair per byte, and releases the CPU.
- When idle, the block is a transparent pass-through of the CPU bus.

Parameters:
- DMA_REG_ADDR, 16'h4014: CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004: destination address for every DMA write.
- XFER_LEN, 256: bytes per transfer. The index counter is clog2(XFER_LEN) bits wide.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_d_out  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe; 1 = write this cycle.
- cpu_d_in  out  8  read data to CPU; always equal to bus_d_in.
- cpu_rdy  out  1  0 = CPU must hold all state (stall).
- bus_addr  out  16  system bus address.
- bus_d_out  out  8  system bus write data.
- bus_we  out  1  system bus write strobe.
- bus_d_in  in  8  system bus read data; combinational, valid in the same cycle as bus_addr.
- dma_active  out  1  1 while the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, index=0, data_buf=0, cyc_odd=0.
  - cpu_rdy=1, dma_active=0, and outputs in pass-through.
- cyc_odd: a flip-flop that toggles every clock from reset. It defines bus cycle parity. DMA reads occur only on cycles where cyc_odd=0.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_we=cpu_we.
  - If cpu_we=1 and cpu_addr==DMA_REG_ADDR: latch page<=cpu_d_out, index<=0, next state HALT. The trigger write itself still reaches the bus unchanged.
- HALT:
  - cpu_rdy=0, bus_we=0, bus_addr=cpu_addr (dummy cycle).
  - Next state is READ if cyc_odd=1 in this cycle; otherwise ALIGN.
- ALIGN: cpu_rdy=0, bus_we=0, bus_addr=cpu_addr. Next state READ.
- READ:
  - cpu_rdy=0, bus_addr={page,index}, bus_we=0.
  - data_buf<=bus_d_in. Next state WRITE.
- WRITE:
  - cpu_rdy=0, bus_addr=OAM_DATA_ADDR, bus_d_out=data_buf, bus_we=1.
  - If index==XFER_LEN-1: next state IDLE and index<=0. Otherwise index<=index+1 and next state READ.
- Outputs cpu_rdy and dma_active are decoded from the registered state (Moore). cpu_rdy returns to 1 in the first IDLE cycle after the final WRITE.
- Stall length after the trigger cycle:
  - 513 cycles (HALT + 256×(READ+WRITE)) if the trigger cycle has cyc_odd=0.
  - 514 cycles (adds ALIGN) if the trigger cycle has cyc_odd=1.
- index wrap: the counter is not allowed to wrap past XFER_LEN-1; termination is by compare, not by overflow.
- Page $FF source range is $FF00–$FFFF; no carry into a wider address.
- Writes to DMA_REG_ADDR while not IDLE are ignored. The CPU is stalled, so any such write is a stale held value.
- cpu_we asserted while cpu_rdy=0 is never forwarded to the bus.
- Reset asserted mid-transfer aborts immediately: IDLE, cpu_rdy=1, no further bus writes. A partial OAM fill is acceptable.
- A trigger in the first IDLE cycle after completion is accepted normally (back-to-back DMAs).

Decomposition:
- Shared package `nes_pkg` holds:
  - the dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE};
  - address constants OAM_DMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004, used as parameter defaults;
  - the bus address/data width constants.
- Single module; no sub-module is needed. The parity flip-flop, index counter and state register all live in oam_dma.

Test Plan:
- Idle pass-through:
  - Stimulus: CPU read $8000 with bus_d_in=8'hA9.
  - Required: bus_addr=$8000, cpu_d_in=8'hA9, cpu_rdy=1, bus_we=0.
  - Stimulus: CPU write $0200←8'h55.
  - Required: bus_we=1, bus_d_out=8'h55.
- Even-cycle trigger:
  - Stimulus: write $4014←8'h02 when cyc_odd=0, with memory $0200+i = i^8'hFF.
  - Required: cpu_rdy low exactly 513 cycles.
  - Required: 256 writes to $2004 with data 8'hFF,8'hFE,…,8'h00 in order.
  - Required: read addresses $0200…$02FF.
- Odd-cycle trigger: same transfer with trigger on cyc_odd=1. Required: cpu_rdy low exactly 514 cycles, with the ALIGN cycle having bus_we=0.
- Page wrap boundary: trigger with 8'hFF. Required: last read address $FFFF, last write to $2004, return to IDLE with no 257th access.
- Reset mid-transfer: assert rst=0 after the 40th WRITE. Required: cpu_rdy=1 and bus_we=0 immediately (asynchronous); no further $2004 writes after release.
- Back-to-back triggers:
  - Stimulus: second $4014←8'h03 write in the first cycle cpu_rdy=1.
  - Required: a new transfer from $0300.
  - Stimulus: a $4014 write held during the stall.
  - Required: no restart.
